// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR datapath: sample and byte widths, the signed
// sample type, and the sign-extension helper used by the input packer and the
// output stage.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int SAMPLE_W = 32;
    localparam int BYTE_W   = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Sign-extend the low nbytes bytes of word to a full sample. Any nbytes
    // outside 1..3 returns the word unchanged (full 4-byte sample).
    function automatic sample_t sext_bytes(input logic [SAMPLE_W-1:0] word,
                                           input int unsigned         nbytes);
        sample_t res;
        case (nbytes)
            32'd1:   res = {{24{word[7]}},  word[7:0]};
            32'd2:   res = {{16{word[15]}}, word[15:0]};
            32'd3:   res = {{8{word[23]}},  word[23:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fir_word_fifo.sv
// -----------------------------------------------------------------------------
// fir_word_fifo
// Small synchronous FIFO of signed samples. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter. The caller
// is responsible for never pushing when full (unless popping) and never
// popping when empty.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_push      write i_wdata at the tail
//   i_pop       discard the head entry
//   i_wdata     sample to write
//   o_head      current head entry (combinational from storage)
//   o_level     occupancy, 0..DEPTH
//   o_full      level == DEPTH
//   o_empty     level == 0
// -----------------------------------------------------------------------------
module fir_word_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  sample_t                i_wdata,
    output sample_t                o_head,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    sample_t     r_mem [DEPTH];

    // Storage and pointer update; storage is cleared on reset so nothing stale survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_level == DEPTH_L);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fir_sample_packer.sv
// -----------------------------------------------------------------------------
// fir_sample_packer
// Packs a little-endian byte stream into signed 32-bit samples, buffers them
// in a small FIFO and presents the head to the FIR core's x input. When the
// FIFO is empty the last popped sample is repeated so the core never sees X.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   byte_in     data byte, accepted when byte_vld is high
//   byte_vld    one byte accepted per high cycle
//   frame_sync  drop any partial word; a byte in the same cycle becomes byte 0
//   x_take      core consumes x_dat this cycle
//   clr_flags   clear sticky overflow/underflow (a same-cycle set wins)
//   x_dat       sample to the core (FIFO head, else hold register)
//   x_vld       FIFO not empty
//   level       FIFO occupancy
//   byte_cnt    bytes held in the partial word
//   overflow    sticky: completed word dropped on a full FIFO
//   underflow   sticky: x_take while FIFO empty
// -----------------------------------------------------------------------------
module fir_sample_packer
    import fir_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH          = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BYTE_W-1:0]      byte_in,
    input  logic                   byte_vld,
    input  logic                   frame_sync,
    input  logic                   x_take,
    input  logic                   clr_flags,
    output logic [SAMPLE_W-1:0]    x_dat,
    output logic                   x_vld,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             byte_cnt,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [SAMPLE_W-1:0]    r_word;
    logic [1:0]             r_byte_cnt;
    sample_t                r_hold;
    logic                   r_overflow;
    logic                   r_underflow;

    logic [1:0]             w_idx;
    logic [SAMPLE_W-1:0]    w_base;
    logic [SAMPLE_W-1:0]    w_asm;
    logic                   w_done;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ovf_set;
    logic                   w_unf_set;
    sample_t                w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_level;

    // Byte placement: frame_sync restarts the word so the current byte is byte 0.
    always_comb begin
        w_idx  = frame_sync ? 2'd0 : r_byte_cnt;
        w_base = frame_sync ? '0 : r_word;
        w_asm  = w_base;
        case (w_idx)
            2'd0:    w_asm[7:0]   = byte_in;
            2'd1:    w_asm[15:8]  = byte_in;
            2'd2:    w_asm[23:16] = byte_in;
            2'd3:    w_asm[31:24] = byte_in;
            default: w_asm        = w_base;
        endcase
    end

    assign w_done = byte_vld && (w_idx == LAST_IDX);

    // A pop only happens on a non-empty FIFO; a push on a full FIFO needs a
    // concurrent pop to make room, otherwise the word is dropped.
    assign w_pop     = x_take && !w_empty;
    assign w_push    = w_done && (!w_full || w_pop);
    assign w_ovf_set = w_done && w_full && !w_pop;
    assign w_unf_set = x_take && w_empty;

    fir_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (sext_bytes(w_asm, BYTES_PER_WORD)),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Partial-word register and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= '0;
            r_byte_cnt <= 2'd0;
        end else if (byte_vld) begin
            r_word     <= w_done ? '0 : w_asm;
            r_byte_cnt <= w_done ? 2'd0 : (w_idx + 2'd1);
        end else if (frame_sync) begin
            r_word     <= '0;
            r_byte_cnt <= 2'd0;
        end else begin
            r_word     <= r_word;
            r_byte_cnt <= r_byte_cnt;
        end
    end

    // Hold register: remembers the last popped sample for the empty case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_pop) begin
            r_hold <= w_head;
        end else begin
            r_hold <= r_hold;
        end
    end

    // Sticky flags; a set in the same cycle as clr_flags wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_flags) begin
                r_underflow <= 1'b0;
            end else begin
                r_underflow <= r_underflow;
            end
        end
    end

    assign x_dat     = w_empty ? r_hold : w_head;
    assign x_vld     = !w_empty;
    assign level     = w_level;
    assign byte_cnt  = r_byte_cnt;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fir_sample_packer.sv
module tb_fir_sample_packer;

    logic        clk;
    logic        rst_n;

    // Instance A: 4 bytes per word, depth 2
    logic [7:0]  a_byte_in;
    logic        a_byte_vld, a_frame_sync, a_x_take, a_clr_flags;
    logic [31:0] a_x_dat;
    logic        a_x_vld;
    logic [1:0]  a_level;
    logic [1:0]  a_byte_cnt;
    logic        a_overflow, a_underflow;

    // Instance B: 1 byte per word, depth 2
    logic [7:0]  b_byte_in;
    logic        b_byte_vld, b_frame_sync, b_x_take, b_clr_flags;
    logic [31:0] b_x_dat;
    logic        b_x_vld;
    logic [1:0]  b_level;
    logic [1:0]  b_byte_cnt;
    logic        b_overflow, b_underflow;

    int n_assert;
    int n_fail;

    fir_sample_packer #(.BYTES_PER_WORD(4), .DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .byte_in(a_byte_in), .byte_vld(a_byte_vld), .frame_sync(a_frame_sync),
        .x_take(a_x_take), .clr_flags(a_clr_flags),
        .x_dat(a_x_dat), .x_vld(a_x_vld), .level(a_level), .byte_cnt(a_byte_cnt),
        .overflow(a_overflow), .underflow(a_underflow)
    );

    fir_sample_packer #(.BYTES_PER_WORD(1), .DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .byte_in(b_byte_in), .byte_vld(b_byte_vld), .frame_sync(b_frame_sync),
        .x_take(b_x_take), .clr_flags(b_clr_flags),
        .x_dat(b_x_dat), .x_vld(b_x_vld), .level(b_level), .byte_cnt(b_byte_cnt),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock on instance A with the given inputs, then inputs return idle.
    task automatic a_cycle(input logic vld, input logic [7:0] b, input logic fs,
                           input logic take, input logic clr);
        a_byte_vld   = vld;
        a_byte_in    = b;
        a_frame_sync = fs;
        a_x_take     = take;
        a_clr_flags  = clr;
        @(posedge clk);
        #1;
        a_byte_vld   = 1'b0;
        a_byte_in    = 8'h00;
        a_frame_sync = 1'b0;
        a_x_take     = 1'b0;
        a_clr_flags  = 1'b0;
    endtask

    task automatic b_cycle(input logic vld, input logic [7:0] b, input logic fs,
                           input logic take, input logic clr);
        b_byte_vld   = vld;
        b_byte_in    = b;
        b_frame_sync = fs;
        b_x_take     = take;
        b_clr_flags  = clr;
        @(posedge clk);
        #1;
        b_byte_vld   = 1'b0;
        b_byte_in    = 8'h00;
        b_frame_sync = 1'b0;
        b_x_take     = 1'b0;
        b_clr_flags  = 1'b0;
    endtask

    // Four bytes of one word, LSB first; x_take/clr_flags apply on the last byte.
    task automatic a_word(input logic [31:0] w, input logic take_last, input logic clr_last);
        a_cycle(1'b1, w[7:0],   1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, w[15:8],  1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, w[23:16], 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, w[31:24], 1'b0, take_last, clr_last);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        a_byte_in = 8'h00; a_byte_vld = 1'b0; a_frame_sync = 1'b0; a_x_take = 1'b0; a_clr_flags = 1'b0;
        b_byte_in = 8'h00; b_byte_vld = 1'b0; b_frame_sync = 1'b0; b_x_take = 1'b0; b_clr_flags = 1'b0;
        #3;
        chk("rst_x_dat",     a_x_dat, 32'h0);
        chk("rst_x_vld",     {31'd0, a_x_vld}, 32'd0);
        chk("rst_level",     {30'd0, a_level}, 32'd0);
        chk("rst_byte_cnt",  {30'd0, a_byte_cnt}, 32'd0);
        chk("rst_overflow",  {31'd0, a_overflow}, 32'd0);
        chk("rst_underflow", {31'd0, a_underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic packing 0x11,0x22,0x33,0x44
        a_cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        chk("pack_cnt1", {30'd0, a_byte_cnt}, 32'd1);
        a_cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        chk("pack_cnt3", {30'd0, a_byte_cnt}, 32'd3);
        chk("pack_vld_before", {31'd0, a_x_vld}, 32'd0);
        a_cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        chk("pack_vld",   {31'd0, a_x_vld}, 32'd1);
        chk("pack_dat",   a_x_dat, 32'h44332211);
        chk("pack_level", {30'd0, a_level}, 32'd1);
        chk("pack_cnt0",  {30'd0, a_byte_cnt}, 32'd0);

        // Pop: FIFO empties, hold register shows popped word
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("pop_vld",  {31'd0, a_x_vld}, 32'd0);
        chk("pop_hold", a_x_dat, 32'h44332211);
        chk("pop_unf",  {31'd0, a_underflow}, 32'd0);

        // Underflow on empty
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("unf_flag", {31'd0, a_underflow}, 32'd1);
        chk("unf_hold", a_x_dat, 32'h44332211);
        a_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("unf_clr",  {31'd0, a_underflow}, 32'd0);

        // Overflow: three words into depth 2
        a_word(32'hA1A2A3A4, 1'b0, 1'b0);
        a_word(32'hB1B2B3B4, 1'b0, 1'b0);
        chk("ovf_level2", {30'd0, a_level}, 32'd2);
        chk("ovf_none",   {31'd0, a_overflow}, 32'd0);
        a_word(32'hC1C2C3C4, 1'b0, 1'b0);
        chk("ovf_level",  {30'd0, a_level}, 32'd2);
        chk("ovf_flag",   {31'd0, a_overflow}, 32'd1);
        chk("ovf_head",   a_x_dat, 32'hA1A2A3A4);
        a_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr",    {31'd0, a_overflow}, 32'd0);

        // Full with push and pop together: no overflow, level unchanged
        a_word(32'hD1D2D3D4, 1'b1, 1'b0);
        chk("fpp_level", {30'd0, a_level}, 32'd2);
        chk("fpp_ovf",   {31'd0, a_overflow}, 32'd0);
        chk("fpp_head",  a_x_dat, 32'hB1B2B3B4);

        // Overflow set beats clr_flags in the same cycle
        a_word(32'hE1E2E3E4, 1'b0, 1'b1);
        chk("setwin_ovf",  {31'd0, a_overflow}, 32'd1);
        chk("setwin_head", a_x_dat, 32'hB1B2B3B4);
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("drain1_head", a_x_dat, 32'hD1D2D3D4);
        chk("drain1_ovf",  {31'd0, a_overflow}, 32'd0);
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("drain2_vld",  {31'd0, a_x_vld}, 32'd0);
        chk("drain2_hold", a_x_dat, 32'hD1D2D3D4);

        // Empty with push and x_take together: underflow, word kept
        a_word(32'hF0302010, 1'b1, 1'b0);
        chk("epp_unf",   {31'd0, a_underflow}, 32'd1);
        chk("epp_level", {30'd0, a_level}, 32'd1);
        chk("epp_dat",   a_x_dat, 32'hF0302010);
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("epp_clr",   {31'd0, a_underflow}, 32'd0);
        chk("epp_level0", {30'd0, a_level}, 32'd0);

        // frame_sync with a byte realigns
        a_cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        chk("fs_cnt2", {30'd0, a_byte_cnt}, 32'd2);
        a_cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        chk("fs_cnt1", {30'd0, a_byte_cnt}, 32'd1);
        a_cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        chk("fs_dat",   a_x_dat, 32'h04030201);
        chk("fs_level", {30'd0, a_level}, 32'd1);
        // frame_sync alone drops the partial byte
        a_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fs_alone_cnt",   {30'd0, a_byte_cnt}, 32'd0);
        chk("fs_alone_level", {30'd0, a_level}, 32'd1);
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset mid-burst with level 2 and byte_cnt 3
        a_word(32'h77777777, 1'b0, 1'b0);
        a_word(32'h66666666, 1'b0, 1'b0);
        a_cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", {30'd0, a_level}, 32'd2);
        chk("pre_rst_cnt",   {30'd0, a_byte_cnt}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_x_dat", a_x_dat, 32'h0);
        chk("arst_vld",   {31'd0, a_x_vld}, 32'd0);
        chk("arst_level", {30'd0, a_level}, 32'd0);
        chk("arst_cnt",   {30'd0, a_byte_cnt}, 32'd0);
        #1;
        rst_n = 1'b1;
        a_word(32'h0D7C6B5A, 1'b0, 1'b0);
        chk("post_rst_dat",   a_x_dat, 32'h0D7C6B5A);
        chk("post_rst_level", {30'd0, a_level}, 32'd1);

        // Instance B: one byte per word, sign extension
        chk("b_rst_dat", b_x_dat, 32'h0);
        b_cycle(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        chk("b_neg_dat",   b_x_dat, 32'hFFFFFF80);
        chk("b_neg_level", {30'd0, b_level}, 32'd1);
        chk("b_cnt",       {30'd0, b_byte_cnt}, 32'd0);
        b_cycle(1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
        chk("b_pos_dat",   b_x_dat, 32'h0000007F);
        chk("b_pos_level", {30'd0, b_level}, 32'd1);
        b_cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("b_fs_level",  {30'd0, b_level}, 32'd2);
        chk("b_fs_head",   b_x_dat, 32'h0000007F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sample_packer.md
# fir_sample_packer

Upstream input stage for the FIR core. Packs the 8-bit byte stream arriving on the TinyTapeout dedicated inputs into signed 32-bit samples and buffers them in a small FIFO. Presents each sample on the core's 32-bit `x` input, and advances one sample each time the core's FSM takes a sample in its main input state. Replaces the direct zero-padded `ui_in` to `x` connection in the top-level wrapper.

## Interface
Parameters:
- `BYTES_PER_WORD`, default 4: bytes per sample, legal values 1..4. If less than 4, the packed word is sign-extended to 32 bits.
- `DEPTH`, default 2: FIFO depth in words, a power of two, at least 2.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  active-low reset, asynchronous assert.
- `byte_in`  in  8  data byte.
- `byte_vld`  in  1  `byte_in` is valid this cycle; one byte is accepted per high cycle.
- `frame_sync`  in  1  discards any partial word and realigns the byte counter.
- `x_take`  in  1  the FIR core samples `x_dat` this cycle (its main input state).
- `clr_flags`  in  1  synchronous clear of the sticky flags.
- `x_dat`  out  32  sample presented to the FIR core.
- `x_vld`  out  1  FIFO not empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `byte_cnt`  out  2  bytes held in the partial word.
- `overflow`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `underflow`  out  1  sticky: `x_take` arrived while the FIFO was empty.

Reset values:
- All outputs 0: `x_dat`, `x_vld`, `level`, `byte_cnt`, `overflow`, `underflow`.
- Internal hold register 0, FIFO empty.

## Operation
Packing:
- Little-endian: the first byte after reset, `frame_sync` or a completed word lands in bits [7:0]; byte k lands in bits [8k+7:8k].
- The word completes on byte number `BYTES_PER_WORD`. Bits above `8*BYTES_PER_WORD-1` are copies of bit `8*BYTES_PER_WORD-1`.
- `byte_cnt` counts 0..`BYTES_PER_WORD`-1 and wraps to 0 when a word completes. It is always 0 when `BYTES_PER_WORD`=1.

`frame_sync`:
- Alone: partial bytes are discarded and `byte_cnt` goes to 0.
- With `byte_vld`: partial bytes are discarded and the current byte becomes byte 0. If `BYTES_PER_WORD`=1, that byte completes a word.

FIFO:
- Push on word completion; pop on `x_take` when `x_vld` is high.
- Full with no pop: the completed word is dropped, `overflow` is set, and FIFO contents are unchanged.
- Full with push and pop in the same cycle: both are performed and `level` is unchanged. No overflow.
- Empty with push and `x_take` in the same cycle: the pop is not performed, `underflow` is set, and the word is pushed.

Output select:
- When `x_vld` is high, `x_dat` is the FIFO head (combinational from FIFO storage).
- When `x_vld` is low, `x_dat` is the hold register: the last popped word, or 0 after reset. The core therefore sees a stable repeated sample on underflow, never X.

Flags:
- `overflow` and `underflow` stay set until `clr_flags` or reset.
- If `clr_flags` and a set condition occur in the same cycle, set wins.

Reset mid-word or mid-burst: all state is cleared immediately and no partial data survives.

## Timing
- Byte-to-sample latency: if the completing byte is sampled at edge t, then `x_vld`, `x_dat` and `level` reflect it after edge t. They are visible to the core in the cycle following t.
- Pop: after the edge where `x_take` is high, `x_dat` shows the next head, or the popped word via the hold register if the FIFO is now empty.
- Throughput: one byte per clock. Sustained input rate must not exceed one word per FIR iteration, otherwise overflow is reported.
- Reset: `rst_n` low clears all registers asynchronously; release is synchronised in the wrapper.
- No combinational path from `byte_in`/`byte_vld` to any output. `x_take` affects outputs only after the next clock edge.

## Structure
- Shared package `fir_pkg`:
  - `SAMPLE_W`=32
  - `BYTE_W`=8
  - typedef `sample_t` (signed [31:0])
  - function `sext_bytes(word, nbytes)`, also to be used by the output stage.
- One sub-module, `fir_word_fifo`:
  - parameterised `DEPTH`, `sample_t` entries
  - read/write pointers with an extra wrap bit
  - outputs `level`, `full`, `empty`, `head`
- Packer register, byte counter, hold register and flags live in the top of this block.

## Test plan
- `BYTES_PER_WORD`=4, bytes 0x11,0x22,0x33,0x44 on consecutive cycles → after the 4th edge `x_vld`=1, `x_dat`=0x44332211, `level`=1.
- `BYTES_PER_WORD`=1, byte 0x80 → `x_dat`=0xFFFFFF80; byte 0x7F → 0x0000007F.
- Default parameters, 3 words pushed with no `x_take` → `level`=2, `overflow`=1, head is still the first word; `clr_flags` → `overflow`=0.
- Empty FIFO, `x_take` pulse → `underflow`=1 and `x_dat` holds the previous popped word (0 after reset).
- Bytes 0xAA,0xBB, then `frame_sync` together with byte 0x01, then 0x02,0x03,0x04 → `x_dat`=0x04030201.
- Assert `rst_n` low while `level`=2 and `byte_cnt`=3 → all outputs 0 before the next clock edge; after release the next 4 bytes form a clean word.
